cpu_mem_bridge: RTL
===================

Name: cpu_mem_bridge

Overview:
- Sits directly downstream of the single-cycle CPU. Merges its instruction-fetch port and data port onto one single-ported, handshaked external memory bus.
- Performs byte-lane alignment so the CPU's load-extension logic always sees the addressed byte or halfword in the low bits.
- Holds one outstanding transaction at a time. Data accesses take priority over fetches.
- Returns completion pulses to the CPU, with a timeout and error flag for hung transactions.

Parameters:
- TIMEOUT_CYC, 255: cycles to wait for mem_gnt or mem_rvalid before aborting; 0 disables the timeout.
- NOP_INSTR, 32'h00000013: word returned on instr_out when a fetch times out.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- instr_read  in  1  CPU requests a fetch (level)
- instr_addr  in  32  fetch byte address; bits [1:0] ignored
- instr_out  out  32  fetched instruction, held until the next fetch completes
- instr_valid  out  1  one-cycle pulse when instr_out updates
- data_read  in  1  CPU load request (level)
- data_write  in  4  store byte enables, already lane-positioned (level; nonzero means store)
- data_addr  in  32  load/store byte address
- data_in  in  32  store data, right-justified
- data_out  out  32  load data, right-shifted by 8*data_addr[1:0]; held until the next load completes
- data_valid  out  1  one-cycle pulse when a load or store completes
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables
- mem_addr  out  32  word address (low 2 bits forced to 0)
- mem_wdata  out  32  write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response valid (reads and writes)
- mem_rdata  in  32  read data
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; all outputs 0 except instr_out = NOP_INSTR.
  - Internal flags d_done = 0, i_buf_valid = 0, last_iaddr = 0, timeout counter = 0.
- FSM states: IDLE, DREQ, DWAIT, IREQ, IWAIT.
- Request detection:
  - Data pending when (data_read | |data_write) & !d_done.
  - d_done clears in any cycle where data_read=0 and data_write=0, or data_addr differs from the captured address.
  - Fetch pending when instr_read & (!i_buf_valid | instr_addr[31:2] != last_iaddr[31:2]).
- IDLE:
  - Data pending: capture addr, be, wdata, and the we/read kind; go to DREQ.
  - Else fetch pending: capture addr; go to IREQ.
  - Both pending in the same cycle: data wins; the fetch is serviced afterwards.
- DREQ / IREQ:
  - mem_req=1 with captured fields.
  - mem_wdata = data_in << 8*addr[1:0]; mem_be = data_write for stores, 4'b1111 for reads.
  - Fields are stable until mem_gnt=1, then go to the *WAIT state with mem_req dropping next cycle.
  - mem_gnt and mem_rvalid in the same cycle are legal: the response is taken and the state goes straight to IDLE.
- DWAIT, on mem_rvalid:
  - Load: data_out <= mem_rdata >> 8*addr[1:0].
  - data_valid pulses; d_done=1; state returns to IDLE.
- IWAIT, on mem_rvalid:
  - instr_out <= mem_rdata; instr_valid pulses.
  - last_iaddr <= captured addr; i_buf_valid=1; state returns to IDLE.
- Latency: minimum 3 cycles from request seen in IDLE to the valid pulse (IDLE→REQ, REQ→WAIT, WAIT→IDLE), shorter by one if gnt and rvalid coincide.
- Timeout:
  - The counter resets on every state entry and increments in REQ/WAIT.
  - At TIMEOUT_CYC: abort, set bus_err, pulse the matching valid.
  - Fetch abort: instr_out = NOP_INSTR. Load abort: data_out = 0.
  - Return to IDLE; mem_req drops immediately.
- bus_err clears only on reset.
- mem_rvalid outside a WAIT state is ignored.
- Asynchronous reset mid-transaction abandons it; no valid pulse is issued.

Decomposition:
- Package cpu_mem_pkg holds:
  - state enum (IDLE, DREQ, DWAIT, IREQ, IWAIT);
  - NOP constant;
  - lane-shift helper functions (store align, load align).
- One sub-module, mem_lane_align, which is purely combinational and does the store-left-shift and load-right-shift by addr[1:0].
- The FSM and timeout counter stay in the top module.

Test Plan:
- Fetch: instr_read=1, instr_addr=0x10; mem_gnt after 1 cycle; mem_rvalid next cycle with rdata=0x00500093 → mem_addr=0x10, mem_we=0, instr_out=0x00500093, one instr_valid pulse. Holding the same address issues no new mem_req.
- Byte store: data_write=4'b0100, data_addr=0x22, data_in=0x000000AB → mem_addr=0x20, mem_be=4'b0100, mem_wdata=0x00AB0000, data_valid pulse after rvalid.
- Halfword load: data_read=1, data_addr=0x102, rdata=0xBEEF1234 → mem_addr=0x100, data_out=0x0000BEEF.
- Collision: instr_read with a new address and data_read asserted in the same cycle → data transaction issued first, then the fetch. Exactly one data_valid pulse, then one instr_valid pulse.
- Timeout: TIMEOUT_CYC=8 and mem_gnt held 0 during a fetch → instr_valid after 8 REQ cycles, instr_out=0x00000013, bus_err=1 and staying 1.
- Reset while in DWAIT: mem_req=0, data_valid never pulses, state IDLE; after reset release with the request still asserted, the transaction is reissued.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared state type, constants and byte-lane helpers for the CPU memory bridge
package cpu_mem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DREQ  = 3'd1,
    DWAIT = 3'd2,
    IREQ  = 3'd3,
    IWAIT = 3'd4
  } bridge_state_t;

  // addi x0, x0, 0 : harmless filler when a fetch never returns
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

  // Move right-justified store data up to the lane selected by the byte offset
  function automatic logic [31:0] store_align(input logic [31:0] data, input logic [1:0] lane);
    return data << {lane, 3'b000};
  endfunction

  // Bring the addressed byte/halfword of a bus word down to bit 0
  function automatic logic [31:0] load_align(input logic [31:0] data, input logic [1:0] lane);
    return data >> {lane, 3'b000};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - combinational byte-lane shifter for store and load data
module mem_lane_align
  import cpu_mem_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  output logic [31:0] store_shifted,
  input  logic [31:0] load_data,
  output logic [31:0] load_shifted
);

  assign store_shifted = store_align(store_data, lane);
  assign load_shifted  = load_align(load_data, lane);

endmodule

// File: rtl/cpu_mem_bridge.sv
// rtl/cpu_mem_bridge.sv - merges CPU fetch and data ports onto one handshaked memory bus
module cpu_mem_bridge
  import cpu_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] NOP_INSTR   = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_read,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        data_read,
  input  logic [3:0]  data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  // Counter only needs to reach TIMEOUT_CYC-1; a zero limit disables the abort path
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TLIM = (TIMEOUT_CYC == 0) ? '0 : TW'(TIMEOUT_CYC - 1);
  localparam bit TO_EN = (TIMEOUT_CYC != 0);

  bridge_state_t state, state_d;

  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic [3:0]    d_be;
  logic          d_we;
  logic          d_done;
  logic [31:2]   i_addr;
  logic [31:2]   last_iaddr;
  logic          i_buf_valid;
  logic [TW-1:0] tcnt;

  logic          data_pend;
  logic          fetch_pend;
  logic          expired;
  logic          d_start;
  logic          i_start;
  logic          d_end;
  logic          i_end;
  logic          abort;
  logic [31:0]   store_shifted;
  logic [31:0]   load_shifted;

  // d_done stops a held-level request from being serviced twice
  assign data_pend  = (data_read | (|data_write)) & ~d_done;
  assign fetch_pend = instr_read & (~i_buf_valid | (instr_addr[31:2] != last_iaddr));
  assign expired    = TO_EN && (tcnt == TLIM);

  mem_lane_align u_align (
    .lane          (d_addr[1:0]),
    .store_data    (d_wdata),
    .store_shifted (store_shifted),
    .load_data     (mem_rdata),
    .load_shifted  (load_shifted)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next state, bus outputs and completion strobes; a grant outranks a same-cycle timeout
  always_comb begin
    state_d   = state;
    d_start   = 1'b0;
    i_start   = 1'b0;
    d_end     = 1'b0;
    i_end     = 1'b0;
    abort     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (state)
      IDLE: begin
        if (data_pend) begin
          d_start = 1'b1;
          state_d = DREQ;
        end else if (fetch_pend) begin
          i_start = 1'b1;
          state_d = IREQ;
        end
      end
      DREQ: begin
        mem_req   = 1'b1;
        mem_we    = d_we;
        mem_be    = d_we ? d_be : 4'b1111;
        mem_addr  = {d_addr[31:2], 2'b00};
        mem_wdata = store_shifted;
        if (mem_gnt) begin
          if (mem_rvalid) begin
            d_end   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DWAIT;
          end
        end else if (expired) begin
          abort   = 1'b1;
          d_end   = 1'b1;
          state_d = IDLE;
        end
      end
      DWAIT: begin
        if (mem_rvalid) begin
          d_end   = 1'b1;
          state_d = IDLE;
        end else if (expired) begin
          abort   = 1'b1;
          d_end   = 1'b1;
          state_d = IDLE;
        end
      end
      IREQ: begin
        mem_req  = 1'b1;
        mem_be   = 4'b1111;
        mem_addr = {i_addr, 2'b00};
        if (mem_gnt) begin
          if (mem_rvalid) begin
            i_end   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = IWAIT;
          end
        end else if (expired) begin
          abort   = 1'b1;
          i_end   = 1'b1;
          state_d = IDLE;
        end
      end
      IWAIT: begin
        if (mem_rvalid) begin
          i_end   = 1'b1;
          state_d = IDLE;
        end else if (expired) begin
          abort   = 1'b1;
          i_end   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-state cycle counter: restarts on every state change, runs while a bus phase is open
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   tcnt <= '0;
    else if (state_d != state)  tcnt <= '0;
    else if (state != IDLE)     tcnt <= tcnt + 1'b1;
  end

  // Request capture, response registers, completion pulses and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_addr      <= 32'h0;
      d_wdata     <= 32'h0;
      d_be        <= 4'b0000;
      d_we        <= 1'b0;
      d_done      <= 1'b0;
      i_addr      <= '0;
      last_iaddr  <= '0;
      i_buf_valid <= 1'b0;
      instr_out   <= NOP_INSTR;
      instr_valid <= 1'b0;
      data_out    <= 32'h0;
      data_valid  <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      data_valid  <= d_end;
      instr_valid <= i_end;
      if (d_start) begin
        d_addr  <= data_addr;
        d_be    <= data_write;
        d_wdata <= data_in;
        d_we    <= |data_write;
      end
      if (i_start) begin
        i_addr <= instr_addr[31:2];
      end
      // Completion wins over a release seen in the same cycle
      if (d_end) begin
        d_done <= 1'b1;
        if (!d_we) data_out <= abort ? 32'h0 : load_shifted;
      end else if ((!data_read && (data_write == 4'b0000)) || (data_addr != d_addr)) begin
        d_done <= 1'b0;
      end
      // An aborted fetch still fills the buffer so a held address does not spin on the bus
      if (i_end) begin
        instr_out   <= abort ? NOP_INSTR : mem_rdata;
        last_iaddr  <= i_addr;
        i_buf_valid <= 1'b1;
      end
      if (abort) bus_err <= 1'b1;
    end
  end

endmodule
